// File: rtl/ring_counter_pkg.sv
// Shared definitions for the ring/Johnson sequencer family: mode and direction
// encodings plus the per-mode seed value.
package ring_counter_pkg;

  localparam int unsigned MAX_WIDTH = 32;

  typedef enum logic {
    MODE_RING    = 1'b0,
    MODE_JOHNSON = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  // Seed is returned at full width; callers size it with a WIDTH'() cast.
  function automatic logic [MAX_WIDTH-1:0] seed_of(input mode_e mode);
    logic [MAX_WIDTH-1:0] seed;
    seed = '0;
    if (mode == MODE_RING) seed[0] = 1'b1;
    return seed;
  endfunction

endpackage

// File: rtl/ring_state_decode.sv
// Combinational legality check and binary step index for a ring (one-hot)
// or Johnson (thermometer) shift-register state.
module ring_state_decode
  import ring_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int POS_W = $clog2(2*WIDTH)
) (
  input  logic [WIDTH-1:0] count,
  input  mode_e            mode,
  output logic             valid,
  output logic [POS_W-1:0] position
);

  int unsigned ones;
  int unsigned edges;
  int unsigned idx;
  int unsigned pos;

  always_comb begin
    ones  = 0;
    edges = 0;
    idx   = 0;
    pos   = 0;
    valid = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (count[i]) begin
        ones = ones + 1;
        idx  = i;
      end
    end
    // A thermometer code has at most one boundary between adjacent bits.
    for (int unsigned i = 0; i + 1 < WIDTH; i++) begin
      if (count[i] != count[i+1]) edges = edges + 1;
    end
    if (mode == MODE_RING) begin
      valid = (ones == 1);
      pos   = idx;
    end else begin
      valid = (edges <= 1);
      if (count[0])       pos = ones;
      else if (ones == 0) pos = 0;
      else                pos = 2*WIDTH - ones;
    end
    position = valid ? POS_W'(pos) : '0;
  end

endmodule

// File: rtl/ring_johnson_counter.sv
// Parametrised ring / Johnson shift-register counter with direction control,
// parallel load, illegal-state recovery, wrap pulse and position index.
module ring_johnson_counter
  import ring_counter_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int POS_W = $clog2(2*WIDTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Dir,
  input  logic             Mode,
  input  logic             Load,
  input  logic [WIDTH-1:0] Load_value,
  output logic [WIDTH-1:0] Count_out,
  output logic [POS_W-1:0] Position,
  output logic             Valid,
  output logic             Wrap,
  output logic             Error
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("ring_johnson_counter: WIDTH must be in 2..32");
  end

  mode_e            mode_in, mode_q, mode_d;
  dir_e             dir;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] seed_cur, seed_new, shifted;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             valid;

  assign mode_in  = mode_e'(Mode);
  assign dir      = dir_e'(Dir);
  assign seed_cur = WIDTH'(seed_of(mode_q));
  assign seed_new = WIDTH'(seed_of(mode_in));

  ring_state_decode #(
    .WIDTH (WIDTH),
    .POS_W (POS_W)
  ) u_decode (
    .count    (count_q),
    .mode     (mode_q),
    .valid    (valid),
    .position (Position)
  );

  // Johnson differs from ring only by inverting the bit fed back around.
  always_comb begin
    if (dir == DIR_LEFT)
      shifted = {count_q[WIDTH-2:0], (mode_q == MODE_JOHNSON) ^ count_q[WIDTH-1]};
    else
      shifted = {(mode_q == MODE_JOHNSON) ^ count_q[0], count_q[WIDTH-1:1]};
  end

  always_comb begin
    count_d = count_q;
    mode_d  = mode_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (Load) begin
      count_d = Load_value;
      mode_d  = mode_in;
    end else if (mode_in != mode_q) begin
      count_d = seed_new;
      mode_d  = mode_in;
    end else if (Enable && !valid) begin
      count_d = seed_cur;
      err_d   = 1'b1;
    end else if (Enable) begin
      count_d = shifted;
      wrap_d  = (shifted == seed_cur);
    end
  end

  // Reset value tracks the Mode input so the counter comes up already seeded.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count_q <= seed_new;
      mode_q  <= mode_in;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      mode_q  <= mode_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign Count_out = count_q;
  assign Valid     = valid;
  assign Wrap      = wrap_q;
  assign Error     = err_q;

endmodule

// File: tb/tb_ring_johnson_counter.sv
// Scoreboard bench for ring_johnson_counter at WIDTH=4: directed steps push
// hand-computed expectations, a monitor pops and compares after each edge.
module tb_ring_johnson_counter;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Enable = 1'b0;
  logic       Dir = 1'b0;
  logic       Mode = 1'b0;
  logic       Load = 1'b0;
  logic [3:0] Load_value = '0;
  logic [3:0] Count_out;
  logic [2:0] Position;
  logic       Valid;
  logic       Wrap;
  logic       Error;

  typedef struct packed {
    logic [3:0] cnt;
    logic [2:0] pos;
    logic       v;
    logic       w;
    logic       e;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   vectors = 0;
  int   miscompares = 0;
  event async_chk;

  ring_johnson_counter #(.WIDTH(4)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Enable     (Enable),
    .Dir        (Dir),
    .Mode       (Mode),
    .Load       (Load),
    .Load_value (Load_value),
    .Count_out  (Count_out),
    .Position   (Position),
    .Valid      (Valid),
    .Wrap       (Wrap),
    .Error      (Error)
  );

  always #5 Clock = ~Clock;

  // Monitor: after every rising edge (or an asynchronous check request)
  initial begin
    forever begin
      @(posedge Clock or async_chk);
      #1;
      if (sb.size() != 0) begin
        cur = sb.pop_front();
        vectors++;
        if (Count_out !== cur.cnt) begin
          miscompares++;
          $display("FAIL count vec%0d: got %b want %b", vectors, Count_out, cur.cnt);
        end
        if (Position !== cur.pos) begin
          miscompares++;
          $display("FAIL position vec%0d: got %0d want %0d", vectors, Position, cur.pos);
        end
        if (Valid !== cur.v) begin
          miscompares++;
          $display("FAIL valid vec%0d: got %b want %b", vectors, Valid, cur.v);
        end
        if (Wrap !== cur.w) begin
          miscompares++;
          $display("FAIL wrap vec%0d: got %b want %b", vectors, Wrap, cur.w);
        end
        if (Error !== cur.e) begin
          miscompares++;
          $display("FAIL error vec%0d: got %b want %b", vectors, Error, cur.e);
        end
      end
    end
  end

  // Drive inputs on the falling edge; expectation is for after the next rising edge.
  task automatic step(input logic ld, input logic [3:0] lv, input logic en,
                      input logic dr, input logic md,
                      input logic [3:0] c, input logic [2:0] p,
                      input logic v, input logic w, input logic e);
    @(negedge Clock);
    Load       = ld;
    Load_value = lv;
    Enable     = en;
    Dir        = dr;
    Mode       = md;
    sb.push_back('{cnt: c, pos: p, v: v, w: w, e: e});
  endtask

  initial begin
    // reset state (ring seed) while reset held
    step(0, 4'b0000, 0, 0, 0, 4'b0001, 0, 1, 0, 0);
    repeat (4) @(negedge Clock);
    Reset = 1'b0;

    // ring left
    step(0, 4'b0000, 1, 0, 0, 4'b0010, 1, 1, 0, 0);
    step(0, 4'b0000, 1, 0, 0, 4'b0100, 2, 1, 0, 0);
    step(0, 4'b0000, 1, 0, 0, 4'b1000, 3, 1, 0, 0);
    step(0, 4'b0000, 1, 0, 0, 4'b0001, 0, 1, 1, 0);
    step(0, 4'b0000, 1, 0, 0, 4'b0010, 1, 1, 0, 0);

    // switch to Johnson: resync to seed, no shift
    step(0, 4'b0000, 1, 0, 1, 4'b0000, 0, 1, 0, 0);
    step(0, 4'b0000, 1, 0, 1, 4'b0001, 1, 1, 0, 0);
    step(0, 4'b0000, 1, 0, 1, 4'b0011, 2, 1, 0, 0);
    step(0, 4'b0000, 1, 0, 1, 4'b0111, 3, 1, 0, 0);
    step(0, 4'b0000, 1, 0, 1, 4'b1111, 4, 1, 0, 0);
    step(0, 4'b0000, 1, 0, 1, 4'b1110, 5, 1, 0, 0);
    step(0, 4'b0000, 1, 0, 1, 4'b1100, 6, 1, 0, 0);
    step(0, 4'b0000, 1, 0, 1, 4'b1000, 7, 1, 0, 0);
    step(0, 4'b0000, 1, 0, 1, 4'b0000, 0, 1, 1, 0);
    step(0, 4'b0000, 1, 0, 1, 4'b0001, 1, 1, 0, 0);
    step(0, 4'b0000, 1, 0, 1, 4'b0011, 2, 1, 0, 0);

    // Johnson right from 0011
    step(0, 4'b0000, 1, 1, 1, 4'b0001, 1, 1, 0, 0);
    step(0, 4'b0000, 1, 1, 1, 4'b0000, 0, 1, 1, 0);
    step(0, 4'b0000, 1, 1, 1, 4'b1000, 7, 1, 0, 0);
    step(0, 4'b0000, 1, 1, 1, 4'b1100, 6, 1, 0, 0);
    step(0, 4'b0000, 0, 1, 1, 4'b1100, 6, 1, 0, 0);

    // load illegal ring value together with Enable and mode change
    step(1, 4'b0110, 1, 0, 0, 4'b0110, 0, 0, 0, 0);
    step(0, 4'b0000, 1, 0, 0, 4'b0001, 0, 1, 0, 1);
    step(0, 4'b0000, 1, 0, 0, 4'b0010, 1, 1, 0, 0);
    step(0, 4'b0000, 1, 0, 0, 4'b0100, 2, 1, 0, 0);

    // mode toggle with Enable low
    step(0, 4'b0000, 0, 0, 1, 4'b0000, 0, 1, 0, 0);
    step(0, 4'b0000, 0, 0, 1, 4'b0000, 0, 1, 0, 0);

    // legal Johnson load, then load of the seed (no wrap on load)
    step(1, 4'b0111, 0, 0, 1, 4'b0111, 3, 1, 0, 0);
    step(0, 4'b0000, 1, 0, 1, 4'b1111, 4, 1, 0, 0);
    step(1, 4'b0000, 1, 0, 1, 4'b0000, 0, 1, 0, 0);
    step(0, 4'b0000, 1, 1, 1, 4'b1000, 7, 1, 0, 0);
    step(0, 4'b0000, 1, 0, 1, 4'b0000, 0, 1, 1, 0);
    step(0, 4'b0000, 1, 0, 1, 4'b0001, 1, 1, 0, 0);
    step(0, 4'b0000, 1, 0, 1, 4'b0011, 2, 1, 0, 0);
    step(0, 4'b0000, 1, 0, 1, 4'b0111, 3, 1, 0, 0);

    // asynchronous reset between edges at 0111 (Johnson)
    @(negedge Clock);
    Enable = 1'b0;
    #2;
    Reset = 1'b1;
    sb.push_back('{cnt: 4'b0000, pos: 3'd0, v: 1'b1, w: 1'b0, e: 1'b0});
    ->async_chk;
    step(0, 4'b0000, 0, 0, 1, 4'b0000, 0, 1, 0, 0);
    Reset = 1'b0;
    step(0, 4'b0000, 1, 0, 1, 4'b0001, 1, 1, 0, 0);

    // all-zero loaded in ring mode is illegal; recovery raises Error once
    step(1, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
    step(0, 4'b0000, 1, 0, 0, 4'b0001, 0, 1, 0, 1);
    step(0, 4'b0000, 0, 0, 0, 4'b0001, 0, 1, 0, 0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge Clock);
    #3;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ring_johnson_counter.md
Name: ring_johnson_counter

Overview:
- Parametrised shift-register counter; runtime-selectable ring (one-hot) or Johnson (twisted-ring) sequence.
- Supports direction control, count enable, parallel load and illegal-state self-recovery.
- Provides a wrap pulse and a binary position index.
- Drop-in successor for sequencers and one-hot select generators in the same design.

Parameters:
WIDTH, 4, number of register bits; legal range 2..32 (elaboration error otherwise)
POS_W, $clog2(2*WIDTH), width of Position output (derived, not to be overridden)

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
Enable  input  1  advance one step on this edge
Dir  input  1  0 = shift left (position increments), 1 = shift right (position decrements)
Mode  input  1  0 = ring, 1 = Johnson
Load  input  1  parallel load request
Load_value  input  WIDTH  value written on Load
Count_out  output  WIDTH  counter register
Position  output  POS_W  binary step index of Count_out
Valid  output  1  Count_out is a legal state for current Mode
Wrap  output  1  one-cycle pulse; period completed
Error  output  1  one-cycle pulse; illegal state was recovered

Behaviour:
- Interface: one clock, Clock; reset is asynchronous and active-high, Reset.
- Seed value: ring = {0..0,1}; Johnson = all zeros.
- Reset: Count_out = seed of Mode as sampled during reset. Wrap = 0, Error = 0. Internal mode register = Mode.
- Per-edge priority, highest first:
  1. Load: Count_out <= Load_value, stored as-is, even if illegal.
  2. Mode != registered mode: Count_out <= new seed, mode register updates. Applies regardless of Enable.
  3. Enable with illegal Count_out: Count_out <= seed; Error = 1 next cycle.
  4. Enable with legal Count_out: one shift.
  5. Otherwise hold.
- Shift rules:
  - Ring left: {C[W-2:0], C[W-1]}. Ring right: {C[0], C[W-1:1]}.
  - Johnson left: {C[W-2:0], ~C[W-1]}. Johnson right: {~C[0], C[W-1:1]}.
- Period: ring = WIDTH steps; Johnson = 2*WIDTH steps.
- Legality (combinational, drives Valid):
  - Ring: exactly one bit set.
  - Johnson: thermometer pattern, i.e. 0..01..1 or 1..10..0, including all-0 and all-1.
- Position (combinational from Count_out, zero latency):
  - Ring: index of the set bit.
  - Johnson, C[0]=1: popcount(C).
  - Johnson, C[0]=0: (WIDTH + number of zeros) mod 2*WIDTH.
  - Illegal state: Position = 0.
  - Example, WIDTH=4 Johnson left: 0000,0001,0011,0111,1111,1110,1100,1000 -> 0..7.
- Wrap: registered. Asserts in the cycle after a shift (priority 4 only) whose result equals seed. Either direction. Never on load, mode resync, recovery or reset.
- Error: registered, high exactly one cycle after a priority-3 recovery. Wrap stays 0 in that cycle.
- Dir may change on any edge. It takes effect on that edge's shift with no bubble.
- Reset mid-operation: immediate return to seed, asynchronously. Pending Wrap/Error cleared.
- Load and Enable on the same edge: Load wins, no shift.
- Load and Mode change on the same edge: Load_value stored and mode register updates; no seed load.

Decomposition:
- Shared package ring_counter_pkg:
  - mode constants MODE_RING=0, MODE_JOHNSON=1
  - direction constants DIR_LEFT=0, DIR_RIGHT=1
  - function for seed by mode
- Sub-module ring_state_decode (combinational):
  - input: Count_out, mode
  - outputs: Valid, Position
  - instantiated once; reusable by other sequencers.

Test Plan:
- WIDTH=4, Mode=0, Dir=0, Reset 50ns then Enable=1 -> Count_out 0001,0010,0100,1000,0001. Wrap high one cycle after the 1000->0001 edge. Position 0,1,2,3,0.
- WIDTH=4, Mode=1, Dir=0, Enable=1 -> 0000,0001,0011,0111,1111,1110,1100,1000,0000. Position 0..7,0. Wrap once per 8 steps.
- Mode=1 at state 0011, Dir switches to 1 -> 0001,0000,1000,1100. Position 1,0,7,6. Wrap after reaching 0000.
- Load=1, Load_value=0110, Mode=0 -> Count_out=0110, Valid=0. Next Enable edge -> Count_out=0001, Error=1 for exactly one cycle, Wrap=0.
- Running ring at 0100, Mode toggles to 1 with Enable=0 -> Count_out=0000 next edge. Valid=1, no Wrap, no Error.
- Reset asserted mid-count at 0111 (Johnson), between clock edges -> Count_out=0000 immediately. Wrap=0, Error=0. Load+Enable on the same edge -> Load_value stored, no shift.
